// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame sequencer for the UART receiver.
// Owns the oversampling edge counter and the bit counter. It enables the start,
// parity and stop checkers and the deserializer in turn, and qualifies each
// received byte with a one-cycle DATA_VALID pulse.
// Optional build macro UART_RX_ERR_STAT_EN adds saturating parity/frame error
// counters (PAR_ERR_CNT, FRM_ERR_CNT) with a synchronous CLR_STAT input.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_WD   = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic [PRESC_WD-1:0] PRESCALE,
  input  logic                PAR_EN,
  input  logic                STRT_GLITCH,
  input  logic                PAR_ERR,
  input  logic                STP_ERR,
`ifdef UART_RX_ERR_STAT_EN
  input  logic                CLR_STAT,
  output logic [7:0]          PAR_ERR_CNT,
  output logic [7:0]          FRM_ERR_CNT,
`endif
  output logic                DAT_SAMP_EN,
  output logic [PRESC_WD-1:0] EDGE_CNT,
  output logic                STRT_CHK_EN,
  output logic                PAR_CHK_EN,
  output logic                STP_CHK_EN,
  output logic                DESER_EN,
  output logic                DATA_VALID,
  output logic                PAR_ERR_FLG,
  output logic                FRM_ERR_FLG
);

  // Bit counter spans start bit (0), data bits (1..DATA_WIDTH), parity and stop.
  localparam int                 BIT_W         = $clog2(DATA_WIDTH + 3);
  localparam logic [BIT_W-1:0]    LAST_DATA_BIT = BIT_W'(DATA_WIDTH);
  localparam logic [PRESC_WD-1:0] EDGE_ONE      = PRESC_WD'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PRESC_WD-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                armed_q, armed_d;
  logic                bad_q, bad_d;
  logic [PRESC_WD-1:0] presc_q;
  logic                presc_load;
  logic                last_edge;
  logic [PRESC_WD-1:0] edge_cnt_adv;
  logic [BIT_W-1:0]    bit_cnt_adv;

  // Edge P-1 of the current bit is where every check and shift happens.
  assign last_edge    = (edge_cnt_q == (presc_q - EDGE_ONE));
  assign edge_cnt_adv = last_edge ? '0 : (edge_cnt_q + EDGE_ONE);
  assign bit_cnt_adv  = last_edge ? (bit_cnt_q + 1'b1) : bit_cnt_q;
  assign EDGE_CNT     = edge_cnt_q;

  // Control state: FSM, counters, start arming and the frame-bad flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      armed_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      armed_q    <= armed_d;
      bad_q      <= bad_d;
    end
  end

  // Oversampling ratio captured at start acceptance and held for the frame.
  always_ff @(posedge CLK) begin
    if (presc_load) begin
      presc_q <= PRESCALE;
    end
  end

  // Next-state, counter sequencing and checker/strobe outputs.
  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    armed_d     = armed_q;
    bad_d       = bad_q;
    presc_load  = 1'b0;
    DAT_SAMP_EN = 1'b0;
    STRT_CHK_EN = 1'b0;
    PAR_CHK_EN  = 1'b0;
    STP_CHK_EN  = 1'b0;
    DESER_EN    = 1'b0;
    DATA_VALID  = 1'b0;
    PAR_ERR_FLG = 1'b0;
    FRM_ERR_FLG = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (RX_IN) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // The detect cycle counts as edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = EDGE_ONE;
          presc_load = 1'b1;
        end
      end

      START: begin
        DAT_SAMP_EN = 1'b1;
        edge_cnt_d  = edge_cnt_adv;
        bit_cnt_d   = bit_cnt_adv;
        if (last_edge) begin
          STRT_CHK_EN = 1'b1;
          if (STRT_GLITCH) begin
            state_d    = IDLE;
            armed_d    = 1'b0;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            bad_d      = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        DAT_SAMP_EN = 1'b1;
        edge_cnt_d  = edge_cnt_adv;
        bit_cnt_d   = bit_cnt_adv;
        if (last_edge) begin
          DESER_EN = 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = PAR_EN ? PARITY : STOP;
          end
        end
      end

      PARITY: begin
        DAT_SAMP_EN = 1'b1;
        edge_cnt_d  = edge_cnt_adv;
        bit_cnt_d   = bit_cnt_adv;
        if (last_edge) begin
          PAR_CHK_EN = 1'b1;
          // A parity error still walks through STOP to stay frame aligned.
          if (PAR_ERR) begin
            bad_d       = 1'b1;
            PAR_ERR_FLG = 1'b1;
          end
          state_d = STOP;
        end
      end

      STOP: begin
        DAT_SAMP_EN = 1'b1;
        edge_cnt_d  = edge_cnt_adv;
        bit_cnt_d   = bit_cnt_adv;
        if (last_edge) begin
          STP_CHK_EN = 1'b1;
          if (STP_ERR) begin
            // Disarm so a line stuck low cannot immediately retrigger.
            FRM_ERR_FLG = 1'b1;
            state_d     = IDLE;
            armed_d     = 1'b0;
            edge_cnt_d  = '0;
            bit_cnt_d   = '0;
            bad_d       = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        DATA_VALID = ~bad_q;
        bad_d      = 1'b0;
        bit_cnt_d  = '0;
        if (!RX_IN) begin
          // Back-to-back frame: this cycle is edge 0 of the next start bit.
          state_d    = START;
          edge_cnt_d = EDGE_ONE;
          presc_load = 1'b1;
        end else begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        bad_d      = 1'b0;
      end
    endcase
  end

`ifdef UART_RX_ERR_STAT_EN
  logic [7:0] par_err_cnt_q, par_err_cnt_d;
  logic [7:0] frm_err_cnt_q, frm_err_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // Saturating error statistics; a clear wins over a same-cycle increment.
  always_comb begin
    par_err_cnt_d = par_err_cnt_q;
    frm_err_cnt_d = frm_err_cnt_q;
    if (CLR_STAT) begin
      par_err_cnt_d = '0;
      frm_err_cnt_d = '0;
    end else begin
      if (PAR_ERR_FLG) par_err_cnt_d = sat_inc8(par_err_cnt_q);
      if (FRM_ERR_FLG) frm_err_cnt_d = sat_inc8(frm_err_cnt_q);
    end
  end

  // Error statistic registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt_q <= '0;
      frm_err_cnt_q <= '0;
    end else begin
      par_err_cnt_q <= par_err_cnt_d;
      frm_err_cnt_q <= frm_err_cnt_d;
    end
  end

  assign PAR_ERR_CNT = par_err_cnt_q;
  assign FRM_ERR_CNT = frm_err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// A schedule model pushes the expected cycle of every strobe/check/flag event
// for each frame driven; the monitor pops and compares as the DUT fires them.
module tb_uart_rx_ctrl;
  localparam int PW = 6;
  localparam int DW = 8;

  localparam int EV_STRT  = 0;
  localparam int EV_DESER = 1;
  localparam int EV_PCHK  = 2;
  localparam int EV_PERR  = 3;
  localparam int EV_SCHK  = 4;
  localparam int EV_FERR  = 5;
  localparam int EV_DV    = 6;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  typedef struct {
    int         presc;
    logic [7:0] data;
    logic       pe;
    logic       perr;
    logic       serr;
    int         n_deser;
    int         n_dv;
    int         n_perr;
    int         n_ferr;
  } vec_t;

  logic          CLK;
  logic          RST;
  logic          RX_IN;
  logic [PW-1:0] PRESCALE;
  logic          PAR_EN;
  logic          STRT_GLITCH;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          DAT_SAMP_EN;
  logic [PW-1:0] EDGE_CNT;
  logic          STRT_CHK_EN;
  logic          PAR_CHK_EN;
  logic          STP_CHK_EN;
  logic          DESER_EN;
  logic          DATA_VALID;
  logic          PAR_ERR_FLG;
  logic          FRM_ERR_FLG;
`ifdef UART_RX_ERR_STAT_EN
  logic          CLR_STAT;
  logic [7:0]    PAR_ERR_CNT;
  logic [7:0]    FRM_ERR_CNT;
`endif

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .PRESC_WD   (PW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PRESCALE    (PRESCALE),
    .PAR_EN      (PAR_EN),
    .STRT_GLITCH (STRT_GLITCH),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
`ifdef UART_RX_ERR_STAT_EN
    .CLR_STAT    (CLR_STAT),
    .PAR_ERR_CNT (PAR_ERR_CNT),
    .FRM_ERR_CNT (FRM_ERR_CNT),
`endif
    .DAT_SAMP_EN (DAT_SAMP_EN),
    .EDGE_CNT    (EDGE_CNT),
    .STRT_CHK_EN (STRT_CHK_EN),
    .PAR_CHK_EN  (PAR_CHK_EN),
    .STP_CHK_EN  (STP_CHK_EN),
    .DESER_EN    (DESER_EN),
    .DATA_VALID  (DATA_VALID),
    .PAR_ERR_FLG (PAR_ERR_FLG),
    .FRM_ERR_FLG (FRM_ERR_FLG)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ev_cnt[7];
  ev_t   sb_q[$];
  ev_t   mon_e;
  logic [6:0] mon_ev;
  string ev_name[7] = '{"STRT_CHK_EN", "DESER_EN", "PAR_CHK_EN", "PAR_ERR_FLG",
                        "STP_CHK_EN", "FRM_ERR_FLG", "DATA_VALID"};
  vec_t  vecs[6];
  int    s0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_counts();
    for (int k = 0; k < 7; k++) ev_cnt[k] = 0;
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  function automatic int outs();
    return int'({DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
                 DESER_EN, DATA_VALID, PAR_ERR_FLG, FRM_ERR_FLG});
  endfunction

  // Every event output is matched against the head of the expected-event queue.
  always @(negedge CLK) begin
    mon_ev = {DATA_VALID, FRM_ERR_FLG, STP_CHK_EN, PAR_ERR_FLG,
              PAR_CHK_EN, DESER_EN, STRT_CHK_EN};
    for (int k = 0; k < 7; k++) begin
      if (mon_ev[k]) begin
        ev_cnt[k]++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: %s high at cycle %0d, no event expected", ev_name[k], cyc);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.kind != k || mon_e.cyc != cyc) begin
            n_fail++;
            $display("FAIL sb_event: got %s at cycle %0d, expected %s at cycle %0d",
                     ev_name[k], cyc, ev_name[mon_e.kind], mon_e.cyc);
          end
        end
      end
    end
  end

  // Drives one frame starting now (this cycle is the start-detect edge 0) and
  // queues the expected event schedule. abort_after>0 stops after that many cycles.
  task automatic send_frame(input int p, input logic [7:0] data, input logic pe,
                            input logic perr, input logic serr, input logic stop_val,
                            input int abort_after);
    logic bits[$];
    int   s;
    int   nb;
    int   st;
    int   n;
    s = cyc;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(^data);
    bits.push_back(stop_val);
    nb = bits.size();
    PRESCALE    = PW'(p);
    PAR_EN      = pe;
    PAR_ERR     = perr;
    STP_ERR     = serr;
    STRT_GLITCH = 1'b0;
    push_ev(EV_STRT, s + p - 1);
    for (int i = 0; i < DW; i++) push_ev(EV_DESER, s + p * (i + 1) + p - 1);
    if (pe) begin
      push_ev(EV_PCHK, s + p * (DW + 1) + p - 1);
      if (perr) push_ev(EV_PERR, s + p * (DW + 1) + p - 1);
    end
    st = s + p * (nb - 1) + p - 1;
    push_ev(EV_SCHK, st);
    if (serr) push_ev(EV_FERR, st);
    else if (!perr) push_ev(EV_DV, st + 1);
    n = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < p; c++) begin
        if (abort_after > 0 && n == abort_after) return;
        RX_IN = bits[b];
        tick();
        // The ratio must be held internally; scramble the input after capture.
        if (n == 0) PRESCALE = PW'(p) ^ 6'h18;
        n++;
      end
    end
  endtask

  initial begin
    // presc, data, pe, perr, serr | deser, dv, perr_flg, frm_flg
    vecs[0] = '{8,  8'hA5, 1'b0, 1'b0, 1'b0, 8, 1, 0, 0};
    vecs[1] = '{8,  8'h5A, 1'b1, 1'b1, 1'b0, 8, 0, 1, 0};
    vecs[2] = '{16, 8'h5A, 1'b1, 1'b0, 1'b0, 8, 1, 0, 0};
    vecs[3] = '{32, 8'hFF, 1'b0, 1'b0, 1'b1, 8, 0, 0, 1};
    vecs[4] = '{16, 8'h01, 1'b0, 1'b0, 1'b1, 8, 0, 0, 1};
    vecs[5] = '{8,  8'h00, 1'b0, 1'b0, 1'b0, 8, 1, 0, 0};

    RST = 1'b0; RX_IN = 1'b0; PRESCALE = 6'd8; PAR_EN = 1'b0;
    STRT_GLITCH = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
`ifdef UART_RX_ERR_STAT_EN
    CLR_STAT = 1'b0;
`endif
    zero_counts();
    repeat (3) tick();
    check("rst_edge_cnt", int'(EDGE_CNT), 0);
    check("rst_outputs", outs(), 0);
`ifdef UART_RX_ERR_STAT_EN
    check("rst_par_cnt", int'(PAR_ERR_CNT), 0);
    check("rst_frm_cnt", int'(FRM_ERR_CNT), 0);
`endif

    // Line held low out of reset: not armed, so no start may be accepted.
    RST = 1'b1;
    repeat (10) tick();
    check("unarmed_dat_samp_en", int'(DAT_SAMP_EN), 0);
    check("unarmed_no_start", ev_cnt[EV_STRT], 0);

    // Start glitch at PRESCALE=16.
    RX_IN = 1'b1; STRT_GLITCH = 1'b1; PRESCALE = 6'd16;
    repeat (4) tick();
    zero_counts();
    s0 = cyc;
    push_ev(EV_STRT, s0 + 15);
    RX_IN = 1'b0;
    repeat (3) tick();
    check("glitch_in_start_samp", int'(DAT_SAMP_EN), 1);
    check("glitch_edge_cnt", int'(EDGE_CNT), 3);
    RX_IN = 1'b1;
    repeat (30) tick();
    check("glitch_strt_chk", ev_cnt[EV_STRT], 1);
    check("glitch_deser", ev_cnt[EV_DESER], 0);
    check("glitch_dv", ev_cnt[EV_DV], 0);
    check("glitch_idle_samp", int'(DAT_SAMP_EN), 0);
    STRT_GLITCH = 1'b0;

    for (int i = 0; i < 6; i++) begin
      RX_IN = 1'b1;
      repeat (4) tick();
      zero_counts();
      send_frame(vecs[i].presc, vecs[i].data, vecs[i].pe, vecs[i].perr, vecs[i].serr, 1'b1, 0);
      RX_IN = 1'b1;
      repeat (4) tick();
      check($sformatf("vec%0d_deser", i), ev_cnt[EV_DESER], vecs[i].n_deser);
      check($sformatf("vec%0d_dv", i), ev_cnt[EV_DV], vecs[i].n_dv);
      check($sformatf("vec%0d_par_err_flg", i), ev_cnt[EV_PERR], vecs[i].n_perr);
      check($sformatf("vec%0d_frm_err_flg", i), ev_cnt[EV_FERR], vecs[i].n_ferr);
    end

    // Stop error with the line stuck low afterwards: no retrigger until high.
    RX_IN = 1'b1;
    repeat (4) tick();
    zero_counts();
    send_frame(32, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    RX_IN = 1'b0;
    repeat (60) tick();
    check("ferr_pulse", ev_cnt[EV_FERR], 1);
    check("ferr_no_restart", ev_cnt[EV_STRT], 1);
    check("ferr_idle_samp", int'(DAT_SAMP_EN), 0);
    RX_IN = 1'b1;
    tick();
    zero_counts();
    send_frame(32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    RX_IN = 1'b1;
    repeat (4) tick();
    check("ferr_recover_dv", ev_cnt[EV_DV], 1);

    // Back-to-back frames: next start bit begins in the DONE cycle.
    RX_IN = 1'b1;
    repeat (4) tick();
    zero_counts();
    send_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    RX_IN = 1'b1;
    repeat (4) tick();
    check("b2b_dv", ev_cnt[EV_DV], 2);
    check("b2b_deser", ev_cnt[EV_DESER], 16);

`ifdef UART_RX_ERR_STAT_EN
    check("stat_frm_cnt", int'(FRM_ERR_CNT), 3);
    check("stat_par_cnt", int'(PAR_ERR_CNT), 1);
    CLR_STAT = 1'b1;
    tick();
    send_frame(8, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    RX_IN = 1'b1;
    repeat (2) tick();
    CLR_STAT = 1'b0;
    tick();
    check("stat_clr_priority", int'(PAR_ERR_CNT), 0);
    for (int i = 0; i < 256; i++) begin
      RX_IN = 1'b1;
      tick();
      send_frame(8, 8'(i), 1'b1, 1'b1, 1'b0, 1'b1, 0);
    end
    RX_IN = 1'b1;
    repeat (2) tick();
    check("stat_par_sat", int'(PAR_ERR_CNT), 255);
    check("stat_frm_clear_held", int'(FRM_ERR_CNT), 0);
`endif

    // Reset in the middle of data bit 4 (43 cycles in at PRESCALE=8).
    RX_IN = 1'b1;
    repeat (4) tick();
    send_frame(8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 43);
    check("mid_frame_samp", int'(DAT_SAMP_EN), 1);
    check("mid_frame_edge", int'(EDGE_CNT), 3);
    RST = 1'b0;
    RX_IN = 1'b1;
    #1;
    check("async_rst_outputs", outs(), 0);
    check("async_rst_edge", int'(EDGE_CNT), 0);
    sb_q.delete();
    zero_counts();
    repeat (3) tick();
    RST = 1'b1;
    repeat (20) tick();
    check("post_rst_no_dv", ev_cnt[EV_DV], 0);
    check("post_rst_no_flags", ev_cnt[EV_PERR] + ev_cnt[EV_FERR], 0);
`ifdef UART_RX_ERR_STAT_EN
    check("post_rst_par_cnt", int'(PAR_ERR_CNT), 0);
`endif
    send_frame(8, 8'h69, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    RX_IN = 1'b1;
    repeat (4) tick();
    check("post_rst_frame_dv", ev_cnt[EV_DV], 1);
    check("post_rst_frame_deser", ev_cnt[EV_DESER], 8);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
